instr_mem_prog: RTL
===================

Name: instr_mem_prog

Overview:
- Parametrised program memory for the PIC10F20x core, successor to the single-port fetch RAM.
- Adds a command-driven programming port (set address, write/read with auto-increment, bulk erase) behind a mode FSM.
- The core fetch port keeps 1-cycle read latency and is fenced off with NOPs while programming.
- Sits between the PC/fetch stage and an external ICSP/loader front end.

Parameters:
PIC_INSTR_WIDTH, 12, instruction word width
L2_PIC_INSTR_MEM_DEPTH, 9, address width
PIC_INSTR_MEM_DEPTH, 512, number of words (must equal 2**L2_PIC_INSTR_MEM_DEPTH)
ERASE_VALUE, 12'hFFF, word written by bulk erase
NOP_WORD, 12'h000, word presented to the core while not in RUN

Ports:
clk  in  1  single clock, all logic posedge
rst_n  in  1  synchronous, active-low reset
fetch_addr  in  L2_PIC_INSTR_MEM_DEPTH  core PC
instruction  out  PIC_INSTR_WIDTH  fetched word, registered
instr_valid  out  1  instruction is from memory (0 = NOP_WORD injected)
prog_mode  in  1  level request to enter/stay in programming mode
prog_active  out  1  FSM is in PROG or ERASE
prog_valid  in  1  command valid
prog_ready  out  1  command accepted when prog_valid & prog_ready
prog_cmd  in  2  00 BULK_ERASE, 01 SET_ADDR, 10 WRITE_INC, 11 READ_INC
prog_wdata  in  PIC_INSTR_WIDTH  address (low bits) for SET_ADDR, data for WRITE_INC
prog_rdata  out  PIC_INSTR_WIDTH  read-back data
prog_rvalid  out  1  one-cycle pulse, prog_rdata valid

Behaviour:
- Reset values: instruction=NOP_WORD, instr_valid=0, prog_active=0, prog_ready=0, prog_rdata=0, prog_rvalid=0; internal prog address=0; FSM=RUN. Memory contents are not reset.
- FSM states: RUN, ENTER, PROG, ERASE, EXIT.
  - RUN -> ENTER when prog_mode=1.
  - ENTER -> PROG after 1 cycle (drains the in-flight fetch).
  - PROG -> ERASE on accepted BULK_ERASE.
  - ERASE -> PROG when the erase counter reaches PIC_INSTR_MEM_DEPTH-1 (counter is written on that cycle).
  - PROG -> EXIT when prog_mode=0 and no read is pending.
  - EXIT -> RUN after 1 cycle.
  - prog_mode dropping during ERASE is ignored until the erase completes.
- RUN: instruction<=mem[fetch_addr] every cycle; instr_valid<=1 (1-cycle latency).
- All other states: instruction<=NOP_WORD, instr_valid<=0.
- prog_ready=1 only in PROG, and never on the cycle a READ_INC response is outstanding.
- SET_ADDR: prog address<=prog_wdata[L2-1:0]; upper bits are ignored.
- WRITE_INC: mem[addr]<=prog_wdata; addr<=addr+1. Wraps from DEPTH-1 to 0.
- READ_INC: memory is read on acceptance. prog_rdata/prog_rvalid appear the next cycle (1-cycle latency). addr increments on acceptance, with the same wrap. Back-to-back reads sustain one per 2 cycles.
- BULK_ERASE: writes ERASE_VALUE to addresses 0..DEPTH-1, one per cycle (DEPTH cycles). prog_ready=0 throughout. Prog address is reset to 0 on completion.
- prog_rvalid is a single-cycle pulse and is 0 outside PROG.
- rst_n=0 in any state, mid-erase included: FSM->RUN next edge and outputs take reset values. Partially erased memory is left as-is.
- Commands presented when prog_ready=0 are not accepted; the source holds prog_valid.

Optional Feature:
INSTR_MEM_PARITY_EN:
- With it: each word is stored with an extra even-parity bit computed at write (WRITE_INC or erase). An added output port parity_err (1 bit, reset 0) pulses for one cycle alongside a fetch or read-back whose stored parity mismatches. instr_valid is unchanged.
- Without it: no parity storage and no parity_err port.

Decomposition:
- Shared pic_params package/include holds PIC_INSTR_WIDTH, the depth parameters, the prog_cmd encodings (PCMD_ERASE/SETADDR/WRITE/READ), the FSM state encodings, and NOP_WORD/ERASE_VALUE.
- One sub-module: instr_mem_ram, a single-port synchronous RAM (we, addr, wdata, registered rdata).
- A port mux in instr_mem_prog selects fetch vs programming vs erase counter as the RAM address source.

Test Plan:
- Reset with prog_mode=0, fetch_addr=5 → instruction=12'h000, instr_valid=0; valid=1 one cycle after rst_n rises.
- prog_mode=1, SET_ADDR 0x1FF, WRITE_INC 0xC AA, WRITE_INC 0x030 → mem[0x1FF]=0xCAA, mem[0x000]=0x030 (wrap). Exit, fetch 0x1FF → instruction=0xCAA the next cycle.
- In PROG, SET_ADDR 0x010, READ_INC twice after writing 0x111/0x222 → prog_rvalid pulses with 0x111 then 0x222, and prog_ready is low the cycle after each read accept.
- BULK_ERASE → prog_ready low exactly 512 cycles. Readback of 0x000, 0x100, 0x1FF all = 0xFFF.
- During RUN, raise prog_mode → instr_valid=0 and instruction=NOP_WORD from the ENTER-cycle output onward. Drop it → instr_valid=1 two cycles after EXIT begins.
- rst_n low at erase cycle 100 → FSM in RUN next cycle with prog_active=0. Address 99 is 0xFFF, and address 200 retains its prior value.

Source files
------------

// File: rtl/instr_mem_prog_pkg.sv
// instr_mem_prog_pkg: shared sizes, command and FSM encodings for the programmable instruction memory
package instr_mem_prog_pkg;
  localparam int PIC_INSTR_WIDTH = 12;
  localparam int L2_PIC_INSTR_MEM_DEPTH = 9;
  localparam int PIC_INSTR_MEM_DEPTH = 512;
  localparam logic [PIC_INSTR_WIDTH-1:0] ERASE_VALUE = 12'hFFF;
  localparam logic [PIC_INSTR_WIDTH-1:0] NOP_WORD = 12'h000;
  localparam logic [L2_PIC_INSTR_MEM_DEPTH-1:0] LAST_ADDR = L2_PIC_INSTR_MEM_DEPTH'(PIC_INSTR_MEM_DEPTH - 1);
  typedef enum logic [1:0] {
    PCMD_ERASE   = 2'b00,
    PCMD_SETADDR = 2'b01,
    PCMD_WRITE   = 2'b10,
    PCMD_READ    = 2'b11
  } pcmd_t;
  typedef enum logic [2:0] {
    ST_RUN, ST_ENTER, ST_PROG, ST_ERASE, ST_EXIT
  } state_t;
endpackage

// File: rtl/instr_mem_prog_ram.sv
// instr_mem_prog_ram: single-port synchronous RAM with registered read data
// Ports: clk; we/addr/wdata write on posedge; rdata <= mem[addr] every cycle (old data on a write).
module instr_mem_prog_ram #(
  parameter int W = 12,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/instr_mem_prog.sv
// instr_mem_prog: PIC10F20x program memory with core fetch port and command-driven programming port
// Ports: clk, rst_n (sync, active low); fetch_addr -> instruction/instr_valid (1-cycle latency, NOP while
// programming); prog_mode level request, prog_active status; prog_valid/prog_ready/prog_cmd/prog_wdata
// command handshake; prog_rdata/prog_rvalid read-back pulse.
// Option INSTR_MEM_PARITY_EN: stores an even-parity bit per word and adds output parity_err.
module instr_mem_prog
  import instr_mem_prog_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [L2_PIC_INSTR_MEM_DEPTH-1:0] fetch_addr,
  output logic [PIC_INSTR_WIDTH-1:0]        instruction,
  output logic                              instr_valid,
  input  logic                              prog_mode,
  output logic                              prog_active,
  input  logic                              prog_valid,
  output logic                              prog_ready,
  input  logic [1:0]                        prog_cmd,
  input  logic [PIC_INSTR_WIDTH-1:0]        prog_wdata,
  output logic [PIC_INSTR_WIDTH-1:0]        prog_rdata,
  output logic                              prog_rvalid
`ifdef INSTR_MEM_PARITY_EN
  , output logic                            parity_err
`endif
);
`ifdef INSTR_MEM_PARITY_EN
  localparam int MW = PIC_INSTR_WIDTH + 1;
`else
  localparam int MW = PIC_INSTR_WIDTH;
`endif
  state_t state;
  logic [L2_PIC_INSTR_MEM_DEPTH-1:0] prog_addr, erase_cnt, ram_addr;
  logic [PIC_INSTR_WIDTH-1:0] wd;
  logic [MW-1:0] ram_wdata, ram_rdata;
  logic rd_pend, fetch_q, acc, ram_we;
  assign prog_ready = state == ST_PROG && !rd_pend;
  assign prog_active = state == ST_PROG || state == ST_ERASE;
  assign acc = prog_valid && prog_ready;
  assign ram_addr = state == ST_RUN ? fetch_addr : state == ST_ERASE ? erase_cnt : prog_addr;
  assign ram_we = state == ST_ERASE || (acc && prog_cmd == PCMD_WRITE);
  assign wd = state == ST_ERASE ? ERASE_VALUE : prog_wdata;
`ifdef INSTR_MEM_PARITY_EN
  assign ram_wdata = {^wd, wd};
  // a stored word plus its even-parity bit must xor to zero
  assign parity_err = (fetch_q || rd_pend) && ^ram_rdata;
`else
  assign ram_wdata = wd;
`endif
  // the RAM output register doubles as the instruction / read-back register
  assign instr_valid = fetch_q;
  assign instruction = fetch_q ? ram_rdata[PIC_INSTR_WIDTH-1:0] : NOP_WORD;
  assign prog_rvalid = rd_pend;
  assign prog_rdata = rd_pend ? ram_rdata[PIC_INSTR_WIDTH-1:0] : '0;
  instr_mem_prog_ram #(.W(MW), .AW(L2_PIC_INSTR_MEM_DEPTH)) u_ram (
    .clk(clk),
    .we(ram_we),
    .addr(ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RUN;
      prog_addr <= '0;
      erase_cnt <= '0;
      rd_pend <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      fetch_q <= state == ST_RUN;
      rd_pend <= acc && prog_cmd == PCMD_READ;
      if (acc && (prog_cmd == PCMD_WRITE || prog_cmd == PCMD_READ)) prog_addr <= prog_addr + 1'b1;
      if (acc && prog_cmd == PCMD_SETADDR) prog_addr <= prog_wdata[L2_PIC_INSTR_MEM_DEPTH-1:0];
      case (state)
        ST_RUN:   if (prog_mode) state <= ST_ENTER;
        ST_ENTER: state <= ST_PROG;
        ST_PROG:
          if (acc && prog_cmd == PCMD_ERASE) state <= ST_ERASE;
          // never leave with a read accepted or in flight, so prog_rvalid stays inside PROG
          else if (!prog_mode && !rd_pend && !(acc && prog_cmd == PCMD_READ)) state <= ST_EXIT;
        ST_ERASE: begin
          // counter wraps back to zero on the last write, ready for the next erase
          erase_cnt <= erase_cnt + 1'b1;
          if (erase_cnt == LAST_ADDR) begin
            state <= ST_PROG;
            prog_addr <= '0;
          end
        end
        ST_EXIT:  state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end
endmodule
